hazard_unit_mc: RTL
===================

Name: hazard_unit_mc

Overview:
- Next-generation hazard detection and forwarding unit for the 5-stage MIPS pipeline (FE/ID/EX/MEM/WB).
- Extends the combinational load-use, branch and forwarding logic with:
  - parametrised register-index width;
  - register-0 qualification;
  - a multi-cycle multiply/divide busy tracker (FSM plus counter);
  - variable-latency data-memory wait stalls;
  - a saturating stall-cycle performance counter.
- Sits beside the pipeline latches and drives their stall, flush and forward-mux selects.

Parameters:
- REG_W, 5, register index width.
- MD_LAT, 32, mul/div occupancy in cycles (>=2).
- CNT_W, 6, mul/div counter width; must satisfy 2^CNT_W > MD_LAT.
- PERF_W, 16, stall performance counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- branch_id  in  1  branch instruction in ID.
- rs_id, rt_id  in  REG_W  sources in ID.
- rs_ex, rt_ex  in  REG_W  sources in EX.
- write_reg_ex, write_reg_mem, write_reg_wb  in  REG_W  destinations per stage.
- reg_write_ex, reg_write_mem, reg_write_wb  in  1  destination write enables.
- mem_to_reg_ex, mem_to_reg_mem  in  1  load in EX / MEM.
- md_start_ex  in  1  mult/div entering execution from EX.
- md_use_id  in  1  ID instruction reads HI/LO or is mult/div.
- dmem_req_mem  in  1  MEM-stage access in progress.
- dmem_ready  in  1  data memory completes this cycle.
- perf_clr  in  1  synchronous clear of stall_cycles.
- stall_fe, stall_id, stall_ex, stall_mem  out  1  hold the respective latch.
- flush_ex  out  1  insert bubble into ID/EX.
- flush_wb  out  1  insert bubble into MEM/WB.
- forward_a_id, forward_b_id  out  1  ID branch comparator forward from MEM.
- forward_a_ex, forward_b_ex  out  2  ALU operand select: 00 = reg file, 01 = WB, 10 = MEM.
- md_busy  out  1  mul/div unit occupied.
- stall_cycles  out  PERF_W  count of cycles with stall_fe = 1.

Behaviour:
- Zero qualification: a destination equal to 0 never matches for stall or forward purposes.
- Hazard terms (combinational):
  - lw_stall = mem_to_reg_ex & rt_ex != 0 & (rs_id == rt_ex | rt_id == rt_ex).
  - br_stall = branch_id & [(reg_write_ex & wr_ex != 0 & wr_ex ∈ {rs_id, rt_id}) | (mem_to_reg_mem & wr_mem != 0 & wr_mem ∈ {rs_id, rt_id})].
  - md_stall = md_busy & md_use_id.
  - mem_stall = dmem_req_mem & ~dmem_ready.
- Outputs under mem_stall (highest priority):
  - stall_fe = stall_id = stall_ex = stall_mem = 1.
  - flush_wb = 1, flush_ex = 0.
  - lw_stall, br_stall and md_stall do not also flush EX.
- Outputs otherwise:
  - stall_fe = stall_id = flush_ex = lw_stall | br_stall | md_stall.
  - stall_ex = stall_mem = flush_wb = 0.
- Forwarding, EX:
  - forward_a_ex = 10 if reg_write_mem & wr_mem != 0 & rs_ex == wr_mem.
  - Else 01 if reg_write_wb & wr_wb != 0 & rs_ex == wr_wb.
  - Else 00. MEM wins when MEM and WB both match.
  - forward_b_ex is the same using rt_ex.
- Forwarding, ID: forward_a_id = reg_write_mem & wr_mem != 0 & rs_id == wr_mem; forward_b_id likewise with rt_id.
- Forward selects are valid during stalls; they are not gated.
- Mul/div FSM, states IDLE and BUSY:
  - IDLE -> BUSY on md_start_ex & ~stall_ex; counter loads MD_LAT-1.
  - In BUSY the counter decrements each cycle, independent of mem_stall.
  - Counter == 0 in BUSY -> IDLE next cycle. Occupancy is exactly MD_LAT cycles.
  - md_start_ex while BUSY is ignored; no restart, no counter reload.
  - md_busy = (state == BUSY), registered.
- Perf counter:
  - stall_cycles increments on each cycle with stall_fe = 1.
  - Saturates at all-ones.
  - perf_clr forces 0 next edge and has priority over increment.
- Reset (rst_n = 0, asynchronous):
  - State IDLE, md counter 0, stall_cycles 0, md_busy 0.
  - Combinational outputs follow their inputs.
  - Reset mid-BUSY aborts the operation immediately.
- Latency: all stall, flush and forward outputs are combinational, same cycle. md_busy and stall_cycles are registered with one-edge latency.

Test Plan:
- Load-use: mem_to_reg_ex = 1, rt_ex = 8, rs_id = 8 -> stall_fe = stall_id = flush_ex = 1, stall_ex = 0. Repeat with rt_ex = 0 -> all stalls 0.
- Forward priority: rs_ex = 5, wr_mem = 5, reg_write_mem = 1, wr_wb = 5, reg_write_wb = 1 -> forward_a_ex = 10. Deassert reg_write_mem -> 01. Set wr_mem = wr_wb = 0 -> 00.
- Mul/div, MD_LAT = 4: pulse md_start_ex -> md_busy high for exactly 4 cycles. md_use_id = 1 throughout -> stall_fe high for 4 cycles, then 0. A second md_start_ex during BUSY does not extend occupancy.
- Memory wait: dmem_req_mem = 1, dmem_ready = 0 for 3 cycles while lw_stall is also true -> all four stalls = 1, flush_wb = 1, flush_ex = 0. Ready on cycle 4 -> mem_stall releases and the lw_stall outputs apply.
- Branch: branch_id = 1, reg_write_ex = 1, write_reg_ex = rt_id = 9 -> stall. Same with write_reg_ex = 0 -> no stall.
- Perf/reset: 5 stall cycles -> stall_cycles = 5. perf_clr -> 0. Force to all-ones -> holds. Assert rst_n = 0 mid-BUSY -> md_busy = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc -- hazard detection and forwarding for the 5-stage MIPS pipeline.
//
// Resolves load-use, branch-compare, mul/div occupancy and data-memory wait
// hazards, and steers the EX and ID forwarding muxes.
//
// Ports:
//   clk, rst_n                       clock; asynchronous active-low reset
//   branch_id                        branch instruction in ID
//   rs_id, rt_id, rs_ex, rt_ex       source register indices in ID / EX
//   write_reg_ex/_mem/_wb            destination register index per stage
//   reg_write_ex/_mem/_wb            destination write enable per stage
//   mem_to_reg_ex, mem_to_reg_mem    load instruction in EX / MEM
//   md_start_ex                      mult/div leaving EX into the mul/div unit
//   md_use_id                        ID instruction needs HI/LO or the mul/div unit
//   dmem_req_mem, dmem_ready         MEM access in progress / completing
//   perf_clr                         synchronous clear of stall_cycles
//   stall_fe/_id/_ex/_mem            hold the respective pipeline latch
//   flush_ex, flush_wb               bubble into ID/EX, MEM/WB
//   forward_a_id, forward_b_id       ID branch comparator forward from MEM
//   forward_a_ex, forward_b_ex       ALU operand select 00 RF, 01 WB, 10 MEM
//   md_busy                          mul/div unit occupied (registered)
//   stall_cycles                     saturating count of stall_fe cycles
module hazard_unit_mc #(
  parameter int REG_W  = 5,
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 6,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_id,
  input  logic [REG_W-1:0]  rs_id,
  input  logic [REG_W-1:0]  rt_id,
  input  logic [REG_W-1:0]  rs_ex,
  input  logic [REG_W-1:0]  rt_ex,
  input  logic [REG_W-1:0]  write_reg_ex,
  input  logic [REG_W-1:0]  write_reg_mem,
  input  logic [REG_W-1:0]  write_reg_wb,
  input  logic              reg_write_ex,
  input  logic              reg_write_mem,
  input  logic              reg_write_wb,
  input  logic              mem_to_reg_ex,
  input  logic              mem_to_reg_mem,
  input  logic              md_start_ex,
  input  logic              md_use_id,
  input  logic              dmem_req_mem,
  input  logic              dmem_ready,
  input  logic              perf_clr,
  output logic              stall_fe,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              flush_ex,
  output logic              flush_wb,
  output logic              forward_a_id,
  output logic              forward_b_id,
  output logic [1:0]        forward_a_ex,
  output logic [1:0]        forward_b_ex,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t        md_state;
  logic [CNT_W-1:0] md_cnt;

  logic lw_stall, br_stall, md_stall, mem_stall, hz_stall;

  // Register 0 is hard-wired zero, so a write to it is never a real producer.
  function automatic logic hit(input logic en, input logic [REG_W-1:0] dst,
                               input logic [REG_W-1:0] src);
    return en && (dst != '0) && (dst == src);
  endfunction

  // MEM is the younger producer, so it wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    if (hit(reg_write_mem, write_reg_mem, src))     return 2'b10;
    else if (hit(reg_write_wb, write_reg_wb, src))  return 2'b01;
    else                                            return 2'b00;
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  always_comb begin
    // A load's destination in EX is rt_ex.
    lw_stall  = hit(mem_to_reg_ex, rt_ex, rs_id) || hit(mem_to_reg_ex, rt_ex, rt_id);
    br_stall  = branch_id &&
                (hit(reg_write_ex, write_reg_ex, rs_id)     ||
                 hit(reg_write_ex, write_reg_ex, rt_id)     ||
                 hit(mem_to_reg_mem, write_reg_mem, rs_id)  ||
                 hit(mem_to_reg_mem, write_reg_mem, rt_id));
    md_stall  = md_busy && md_use_id;
    mem_stall = dmem_req_mem && !dmem_ready;
    hz_stall  = lw_stall || br_stall || md_stall;
  end

  // A memory wait freezes the whole pipe; the frozen ID/EX contents are kept,
  // so EX is not flushed even if another hazard is present.
  always_comb begin
    stall_fe  = mem_stall || hz_stall;
    stall_id  = mem_stall || hz_stall;
    stall_ex  = mem_stall;
    stall_mem = mem_stall;
    flush_wb  = mem_stall;
    flush_ex  = !mem_stall && hz_stall;
  end

  always_comb begin
    forward_a_ex = fwd_sel(rs_ex);
    forward_b_ex = fwd_sel(rt_ex);
    forward_a_id = hit(reg_write_mem, write_reg_mem, rs_id);
    forward_b_id = hit(reg_write_mem, write_reg_mem, rt_id);
  end

  // Mul/div occupancy: MD_LAT cycles counted down from MD_LAT-1 to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_state <= IDLE;
      md_cnt   <= '0;
    end else begin
      case (md_state)
        IDLE: begin
          if (md_start_ex && !stall_ex) begin
            md_state <= BUSY;
            md_cnt   <= CNT_W'(MD_LAT - 1);
          end
        end
        BUSY: begin
          if (md_cnt == '0) md_state <= IDLE;
          else              md_cnt   <= md_cnt - CNT_W'(1);
        end
        default: md_state <= IDLE;
      endcase
    end
  end

  assign md_busy = (md_state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        stall_cycles <= '0;
    else if (perf_clr) stall_cycles <= '0;
    else if (stall_fe) stall_cycles <= sat_inc(stall_cycles);
  end

endmodule
